traffic_phase_sequencer: RTL and testbench

TRAFFIC_PHASE_SEQUENCER -- requirements
Module: traffic_phase_sequencer

---
 rtl/traffic_phase_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sequencer.sv
// Two-road traffic light sequencer with a tick prescaler, pedestrian walk insertion
// in the all-red phases and a flashing-yellow mode. All outputs are registered.
module traffic_phase_sequencer #(
    parameter int TICK_DIV  = 10,
    parameter int GREEN_T   = 8,
    parameter int YELLOW_T  = 3,
    parameter int RED_T     = 1,
    parameter int WALK_T    = 4,
    parameter int MIN_GREEN = 3
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       enable,
    input  logic       ped_req,
    input  logic       flash,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [2:0] phase,
    output logic       tick
);

    // state  | meaning
    // NS_G   | north-south green, east-west red
    // NS_Y   | north-south yellow, east-west red
    // RED1   | all red (walk if granted) before east-west green
    // EW_G   | east-west green, north-south red
    // EW_Y   | east-west yellow, north-south red
    // RED2   | all red (walk if granted) before north-south green
    // FLASH  | both roads flash yellow until flash drops
    typedef enum logic [2:0] {
        S_NS_G  = 3'd0,
        S_NS_Y  = 3'd1,
        S_RED1  = 3'd2,
        S_EW_G  = 3'd3,
        S_EW_Y  = 3'd4,
        S_RED2  = 3'd5,
        S_FLASH = 3'd6
    } state_t;

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST    = CW'(TICK_DIV - 1);
    localparam logic [7:0]    GREEN_LAST  = 8'(GREEN_T - 1);
    localparam logic [7:0]    YELLOW_LAST = 8'(YELLOW_T - 1);
    localparam logic [7:0]    RED_LAST    = 8'(RED_T - 1);
    localparam logic [7:0]    WALK_LAST   = 8'(WALK_T - 1);
    localparam logic [7:0]    MIN_LAST    = 8'(MIN_GREEN - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    logic [CW-1:0] cnt;
    logic          tick_now;

    state_t     state, state_nx;
    logic [7:0] timer, timer_nx;
    logic       walk_sel, walk_nx;
    logic       flash_on, flash_on_nx;
    logic       pend, pend_nx, pend_clr;
    logic [7:0] red_last;

    logic [2:0] ns_nx, ew_nx;
    logic       ped_walk_nx;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick_now = enable && (cnt == CNT_LAST);
    assign red_last = walk_sel ? WALK_LAST : RED_LAST;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= S_RED2;
            timer    <= '0;
            walk_sel <= 1'b0;
            flash_on <= 1'b0;
            pend     <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            walk_sel <= walk_nx;
            flash_on <= flash_on_nx;
            pend     <= pend_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        walk_nx     = walk_sel;
        flash_on_nx = flash_on;
        pend_clr    = 1'b0;
        if (tick_now) begin
            if (flash) begin
                if (state == S_FLASH) begin
                    flash_on_nx = ~flash_on;
                end else begin
                    state_nx    = S_FLASH;
                    timer_nx    = '0;
                    walk_nx     = 1'b0;
                    flash_on_nx = 1'b1;
                end
            end else begin
                case (state)
                    S_NS_G, S_EW_G: begin
                        timer_nx = timer + 8'd1;
                        // a pending pedestrian cuts green once the minimum has been served
                        if (timer == GREEN_LAST || (pend && timer >= MIN_LAST)) begin
                            state_nx = (state == S_NS_G) ? S_NS_Y : S_EW_Y;
                            timer_nx = '0;
                        end
                    end
                    S_NS_Y, S_EW_Y: begin
                        timer_nx = timer + 8'd1;
                        if (timer == YELLOW_LAST) begin
                            state_nx = (state == S_NS_Y) ? S_RED1 : S_RED2;
                            timer_nx = '0;
                            walk_nx  = pend;
                            pend_clr = pend;
                        end
                    end
                    S_RED1, S_RED2: begin
                        timer_nx = timer + 8'd1;
                        if (timer == red_last) begin
                            state_nx = (state == S_RED1) ? S_EW_G : S_NS_G;
                            timer_nx = '0;
                            walk_nx  = 1'b0;
                        end
                    end
                    S_FLASH: begin
                        state_nx = S_RED1;
                        timer_nx = '0;
                        walk_nx  = pend;
                        pend_clr = pend;
                    end
                    default: begin
                        state_nx = S_RED2;
                        timer_nx = '0;
                        walk_nx  = 1'b0;
                    end
                endcase
            end
        end
        pend_nx = ped_req | (pend & ~pend_clr);
    end

    // Lamp values are decoded from the next state so the registered outputs track the state registers.
    always_comb begin
        ns_nx       = LAMP_RED;
        ew_nx       = LAMP_RED;
        ped_walk_nx = 1'b0;
        case (state_nx)
            S_NS_G:  ns_nx = LAMP_GREEN;
            S_NS_Y:  ns_nx = LAMP_YELLOW;
            S_EW_G:  ew_nx = LAMP_GREEN;
            S_EW_Y:  ew_nx = LAMP_YELLOW;
            S_RED1, S_RED2: ped_walk_nx = walk_nx;
            S_FLASH: begin
                ns_nx = flash_on_nx ? LAMP_YELLOW : LAMP_OFF;
                ew_nx = flash_on_nx ? LAMP_YELLOW : LAMP_OFF;
            end
            default: begin
                ns_nx = LAMP_RED;
                ew_nx = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            ns_light <= LAMP_RED;
            ew_light <= LAMP_RED;
            ped_walk <= 1'b0;
            phase    <= S_RED2;
            tick     <= 1'b0;
        end else begin
            ns_light <= ns_nx;
            ew_light <= ew_nx;
            ped_walk <= ped_walk_nx;
            phase    <= state_nx;
            tick     <= tick_now;
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: one short-tick instance for prescaler
// timing and one default instance for sequencing, pedestrian, freeze, flash and reset.
module tb_traffic_phase_sequencer;

    logic       clk_in = 1'b0;
    logic       rst, rst_a, enable, ped_req, flash;
    logic [2:0] ns_light, ew_light, phase;
    logic       ped_walk, tick;
    logic [2:0] a_ns, a_ew, a_phase;
    logic       a_walk, a_tick;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_in = ~clk_in;

    traffic_phase_sequencer #(.TICK_DIV(4), .GREEN_T(5), .RED_T(1)) dut_a (
        .clk_in(clk_in), .rst(rst_a), .enable(enable), .ped_req(ped_req), .flash(flash),
        .ns_light(a_ns), .ew_light(a_ew), .ped_walk(a_walk), .phase(a_phase), .tick(a_tick)
    );

    traffic_phase_sequencer dut (
        .clk_in(clk_in), .rst(rst), .enable(enable), .ped_req(ped_req), .flash(flash),
        .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk), .phase(phase), .tick(tick)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic wait_phase(input int target, input int budget, input string tag);
        int k = 0;
        while (int'(phase) != target && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        check(tag, int'(phase), target);
    endtask

    // Counts consecutive cycles in the current phase; stops on the first cycle of the next one.
    task automatic dwell(output int n, output int walk_hi);
        logic [2:0] cur;
        cur = phase;
        n = 0;
        walk_hi = 0;
        while (phase == cur && n < 2000) begin
            n++;
            walk_hi += int'(ped_walk);
            @(negedge clk_in);
        end
    endtask

    task automatic wait_tick(input string tag);
        int k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (tick !== 1'b1 && k < 20);
        check(tag, int'(tick), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    initial begin
        int n, w, a_ng, ticks, moved, tot_walk;
        int exp_dw[6] = '{80, 30, 10, 80, 30, 10};
        int exp_ns[6] = '{1, 2, 4, 4, 4, 4};
        int exp_ew[6] = '{4, 4, 4, 1, 2, 4};

        rst = 1'b1; rst_a = 1'b1; enable = 1'b1; ped_req = 1'b0; flash = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_phase", int'(phase), 5);
        check("rst_ns", int'(ns_light), 4);
        check("rst_ew", int'(ew_light), 4);
        check("rst_walk", int'(ped_walk), 0);
        check("rst_tick", int'(tick), 0);
        check("a_rst_phase", int'(a_phase), 5);

        // Short prescaler: tick every 4th cycle, NS_G after 4 cycles, held 20 cycles
        rst_a = 1'b0;
        a_ng = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            check($sformatf("a_tick_c%0d", k), int'(a_tick), (k % 4 == 0) ? 1 : 0);
            if (k == 3) check("a_phase_before_entry", int'(a_phase), 5);
            if (k == 4) check("a_phase_ns_g_entry", int'(a_phase), 0);
            if (a_phase == 3'd0) a_ng++;
        end
        while (a_phase == 3'd0 && a_ng < 100) begin
            @(negedge clk_in);
            if (a_phase == 3'd0) a_ng++;
        end
        check("a_ns_g_dwell", a_ng, 20);

        // Full default cycle with no requests
        rst = 1'b0;
        wait_phase(0, 40, "first_ns_g");
        tot_walk = 0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("seq_phase%0d", i), int'(phase), i);
            check($sformatf("seq_ns%0d", i), int'(ns_light), exp_ns[i]);
            check($sformatf("seq_ew%0d", i), int'(ew_light), exp_ew[i]);
            dwell(n, w);
            check($sformatf("seq_dwell%0d", i), n, exp_dw[i]);
            tot_walk += w;
        end
        check("seq_no_walk", tot_walk, 0);

        // Pedestrian pulse at NS_G entry: green cut after 3 ticks, RED1 walk for 40 cycles
        check("ped_at_ns_g", int'(phase), 0);
        ped_req = 1'b1;
        @(negedge clk_in);
        ped_req = 1'b0;
        dwell(n, w);
        check("ped_ns_g_dwell", n + 1, 30);
        check("ped_ns_y", int'(phase), 1);
        dwell(n, w);
        check("ped_ns_y_dwell", n, 30);
        check("ped_red1", int'(phase), 2);
        dwell(n, w);
        check("ped_red1_dwell", n, 40);
        check("ped_red1_walk_cycles", w, 40);
        check("ped_ew_g", int'(phase), 3);
        check("ped_ew_g_walk", int'(ped_walk), 0);
        dwell(n, w);
        check("ped_ew_g_dwell", n, 80);

        // Freeze for 50 cycles in the middle of EW_Y
        check("frz_ew_y", int'(phase), 4);
        n = 1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_in);
            if (phase == 3'd4) n++;
        end
        enable = 1'b0;
        ticks = 0;
        moved = 0;
        repeat (50) begin
            @(negedge clk_in);
            ticks += int'(tick);
            if (phase != 3'd4) moved = 1;
            else n++;
        end
        enable = 1'b1;
        while (phase == 3'd4 && n < 200) begin
            @(negedge clk_in);
            if (phase == 3'd4) n++;
        end
        check("frz_ticks", ticks, 0);
        check("frz_moved", moved, 0);
        check("frz_ew_y_total", n, 80);
        check("frz_red2", int'(phase), 5);
        dwell(n, w);
        check("frz_red2_dwell", n, 10);

        // Flash requested during EW_G
        wait_phase(3, 200, "fl_ew_g");
        repeat (15) @(negedge clk_in);
        flash = 1'b1;
        wait_tick("fl_entry_tick");
        check("fl_phase", int'(phase), 6);
        check("fl_ns_on", int'(ns_light), 2);
        check("fl_ew_on", int'(ew_light), 2);
        check("fl_walk", int'(ped_walk), 0);
        for (int k = 1; k <= 3; k++) begin
            wait_tick($sformatf("fl_tick%0d", k));
            check($sformatf("fl_ns%0d", k), int'(ns_light), (k % 2 == 1) ? 0 : 2);
            check($sformatf("fl_ew%0d", k), int'(ew_light), (k % 2 == 1) ? 0 : 2);
            check($sformatf("fl_hold%0d", k), int'(phase), 6);
        end
        flash = 1'b0;
        wait_tick("fl_exit_tick");
        check("fl_exit_red1", int'(phase), 2);
        check("fl_exit_ns", int'(ns_light), 4);
        check("fl_exit_walk", int'(ped_walk), 0);
        dwell(n, w);
        check("fl_red1_dwell", n, 10);
        check("fl_then_ew_g", int'(phase), 3);

        // Reset during a RED1 walk, with a fresh request pending
        ped_req = 1'b1;
        @(negedge clk_in);
        ped_req = 1'b0;
        wait_phase(0, 300, "rw_ns_g");
        ped_req = 1'b1;
        @(negedge clk_in);
        ped_req = 1'b0;
        wait_phase(2, 200, "rw_red1");
        check("rw_red1_walk", int'(ped_walk), 1);
        repeat (3) @(negedge clk_in);
        ped_req = 1'b1;
        @(negedge clk_in);
        ped_req = 1'b0;
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        check("rw_rst_phase", int'(phase), 5);
        check("rw_rst_walk", int'(ped_walk), 0);
        check("rw_rst_ns", int'(ns_light), 4);
        check("rw_rst_tick", int'(tick), 0);
        wait_phase(0, 40, "rw_after_ns_g");
        dwell(n, w);
        check("rw_pending_cleared_ns_g_dwell", n, 80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
